linebuf_bank_ctrl: RTL and testbench
====================================

// Module: linebuf_bank_ctrl
// PURPOSE
//  Ping-pong ownership controller for the two single-port line SRAMs of the line buffer.
//  Tracks each bank as EMPTY/WRITING/FULL/READING and steers pixel writes and reads to banks.
//  Guarantees writer and reader never touch the same bank in one cycle.
//  Counts dropped (overflow) and starved (underflow) lines.
//  Sits between video input/output timing logic and the two SRAM macros.
// PARAMETERS
//  ADDR_WIDTH  6   SRAM address width; line capacity 2**ADDR_WIDTH words
//  DATA_WIDTH  30  pixel word width ({R,G,B})
//  CNT_WIDTH   8   width of the saturating error counters
// PORTS
//  clk         in   1           clock
//  rst         in   1           synchronous active-high reset
//  i_clr_err   in   1           clear both error counters
//  i_wr_sol    in   1           writer start-of-line pulse
//  i_wr_en     in   1           writer pixel beat
//  i_wr_data   in   DATA_WIDTH  writer pixel
//  i_wr_eol    in   1           writer end-of-line pulse
//  i_rd_sol    in   1           reader start-of-line pulse
//  i_rd_en     in   1           reader pixel request
//  i_rd_eol    in   1           reader end-of-line pulse
//  o_cs1/o_cs2      out 1           bank 1/2 chip select
//  o_we1/o_we2      out 1           bank 1/2 write enable
//  o_addr1/o_addr2  out ADDR_WIDTH  bank 1/2 address
//  o_din1/o_din2    out DATA_WIDTH  bank 1/2 write data
//  o_rd_valid  out  1           SRAM read data valid; one cycle after the accepted request
//  o_sel       out  1           bank of o_rd_valid data (0=bank1, 1=bank2)
//  o_bank_st   out  4           {bank2_state, bank1_state}
//  o_ovf_cnt   out  CNT_WIDTH   dropped write lines
//  o_udf_cnt   out  CNT_WIDTH   starved read lines
// BEHAVIOUR
//  Reset: both banks EMPTY, wr_ptr=rd_ptr=bank1, all outputs 0, counters 0.
//  Bank state codes: EMPTY=0, WRITING=1, FULL=2, READING=3.
//  Decisions use registered bank state; there is no same-cycle forwarding.
//  Writer FSM (W_IDLE, W_ACTIVE, W_DROP):
//   - wr_sol, bank[wr_ptr]==EMPTY: go to W_ACTIVE, bank -> WRITING, waddr=0.
//     An i_wr_en in the same cycle is the first beat at addr 0.
//   - wr_sol, bank not EMPTY: go to W_DROP, ovf_cnt+1. Ignore en/eol until the next sol.
//   - wr_sol while W_ACTIVE: restart the line in the same bank, waddr=0.
//   - Beat in W_ACTIVE: cs/we=1 combinationally on the bank, addr=waddr, din=i_wr_data, waddr+1.
//   - Beats after waddr reaches 2**ADDR_WIDTH are discarded; no wrap.
//   - wr_eol: len[bank]=beats stored (including a same-cycle beat), bank -> FULL, wr_ptr toggles, go to W_IDLE.
//  Reader FSM (R_IDLE, R_ACTIVE, R_STARVE):
//   - rd_sol, bank[rd_ptr]==FULL: go to R_ACTIVE, bank -> READING, raddr=0.
//   - rd_sol, bank not FULL: go to R_STARVE, udf_cnt+1. No cs in this state.
//   - rd_en in R_ACTIVE with raddr<len: cs=1, we=0, addr=raddr, raddr+1.
//     Next cycle: o_rd_valid=1 and o_sel=bank.
//   - rd_en with raddr>=len: cs suppressed, o_rd_valid=0 next cycle.
//   - rd_eol in R_ACTIVE: bank -> EMPTY, rd_ptr toggles. In R_STARVE: go to R_IDLE only, ptr unchanged.
//  Same-cycle cases:
//   - wr_eol and rd_sol on the same bank: reader starves.
//   - rd_eol and wr_sol on the same bank: writer drops.
//  Zero-length line (sol then eol, no beats): FULL with len=0. Read consumes it with no cs.
//  Counters saturate at all-ones. i_clr_err has priority over an increment in the same cycle.
//  Unused port lanes drive 0 (addr/din/we), so outputs are safe to OR externally.
//  rst mid-line returns everything to reset state next cycle. Partial line data is abandoned.
// STRUCTURE
//  Package linebuf_pkg: bank state codes, writer/reader state codes, BANK1/BANK2 constants.
//  Sub-module linebuf_bank_fsm: one per bank; holds state and len.
//   Inputs are claim/release pulses from the writer and reader FSMs.
//  Top: writer FSM, reader FSM, ptrs, address counters, port muxing, error counters.
// TESTING
//  1. Reset, write 4 pixels line A to bank1, eol, read 4.
//     -> o_cs1 reads addr 0..3, o_rd_valid 4 cycles, o_sel=0, then bank1 EMPTY.
//  2. Write lines A, B back-to-back, then a third sol with no read.
//     -> banks FULL/FULL, third line dropped, o_ovf_cnt=1, no cs on any bank.
//  3. rd_sol with both banks EMPTY.
//     -> o_udf_cnt=1, no cs, o_rd_valid stays 0 until the next valid line.
//  4. Concurrent write bank2 while reading bank1 every cycle.
//     -> o_cs1 and o_cs2 both high, o_we1=0, o_we2=1, never the same bank twice.
//  5. Write 70 beats with ADDR_WIDTH=6.
//     -> 64 stored, len=64, no wrap. Reading 70 gives 64 o_rd_valid pulses.
//  6. Same-cycle wr_eol/rd_sol on bank1, then i_clr_err during a drop, then rst mid-line.
//     -> udf=1; counter reads 0 after clr; all states EMPTY after rst.

Source files
------------

// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared state codes and bank identifiers for the line buffer controller
package linebuf_pkg;
  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_WRITING = 2'd1, B_FULL = 2'd2, B_READING = 2'd3} bank_st_e;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DROP} wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_STARVE} rd_st_e;
  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;
endpackage

// File: rtl/linebuf_bank_fsm.sv
// linebuf_bank_fsm: ownership state and stored line length of one SRAM bank
module linebuf_bank_fsm
  import linebuf_pkg::*;
#(
  parameter int LW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_claim_i,
  input  logic          wr_done_i,
  input  logic [LW-1:0] wr_len_i,
  input  logic          rd_claim_i,
  input  logic          rd_done_i,
  output bank_st_e      st_o,
  output logic [LW-1:0] len_o
);
  bank_st_e      st_q, st_d;
  logic [LW-1:0] len_q, len_d;
  // next state: each pulse only acts in the state that owns it
  always_comb begin
    st_d  = st_q;
    len_d = len_q;
    if (st_q == B_EMPTY && wr_claim_i) st_d = B_WRITING;
    else if (st_q == B_WRITING && wr_done_i) begin
      st_d  = B_FULL;
      len_d = wr_len_i;
    end
    else if (st_q == B_FULL && rd_claim_i) st_d = B_READING;
    else if (st_q == B_READING && rd_done_i) st_d = B_EMPTY;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= B_EMPTY;
      len_q <= '0;
    end else begin
      st_q  <= st_d;
      len_q <= len_d;
    end
  end
  assign st_o  = st_q;
  assign len_o = len_q;
endmodule

// File: rtl/linebuf_bank_ctrl.sv
// linebuf_bank_ctrl: ping-pong writer/reader steering across two single-port line SRAMs
module linebuf_bank_ctrl
  import linebuf_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 30,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_err,
  input  logic                  i_wr_sol,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_eol,
  input  logic                  i_rd_sol,
  input  logic                  i_rd_en,
  input  logic                  i_rd_eol,
  output logic                  o_cs1,
  output logic                  o_cs2,
  output logic                  o_we1,
  output logic                  o_we2,
  output logic [ADDR_WIDTH-1:0] o_addr1,
  output logic [ADDR_WIDTH-1:0] o_addr2,
  output logic [DATA_WIDTH-1:0] o_din1,
  output logic [DATA_WIDTH-1:0] o_din2,
  output logic                  o_rd_valid,
  output logic                  o_sel,
  output logic [3:0]            o_bank_st,
  output logic [CNT_WIDTH-1:0]  o_ovf_cnt,
  output logic [CNT_WIDTH-1:0]  o_udf_cnt
);
  localparam int LW = ADDR_WIDTH + 1;
  wr_st_e               w_q, w_d;
  rd_st_e               r_q, r_d;
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        waddr_q, waddr_d, raddr_q, raddr_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d, udf_q, udf_d;
  logic                 vld_q, sel_q;
  bank_st_e             bst [2];
  logic [LW-1:0]        blen [2];
  logic                 wr_go, wr_drop, wr_end, wbeat, rd_go, rd_starve, rd_end, rbeat;
  logic [LW-1:0]        wbase, rbase, rlen;
  // a sol while active restarts the same bank; otherwise the owned bank must be free
  assign wr_go     = i_wr_sol && (w_q == W_ACTIVE || bst[wr_ptr_q] == B_EMPTY);
  assign wr_drop   = i_wr_sol && !wr_go;
  assign wr_end    = w_q == W_ACTIVE && !i_wr_sol && i_wr_eol;
  assign wbase     = i_wr_sol ? '0 : waddr_q;
  assign wbeat     = (wr_go || (w_q == W_ACTIVE && !i_wr_sol)) && i_wr_en && !wbase[ADDR_WIDTH];
  assign rd_go     = i_rd_sol && (r_q == R_ACTIVE || bst[rd_ptr_q] == B_FULL);
  assign rd_starve = i_rd_sol && !rd_go;
  assign rd_end    = r_q == R_ACTIVE && !i_rd_sol && i_rd_eol;
  assign rbase     = i_rd_sol ? '0 : raddr_q;
  assign rlen      = blen[rd_ptr_q];
  assign rbeat     = (rd_go || (r_q == R_ACTIVE && !i_rd_sol)) && i_rd_en && rbase < rlen;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    linebuf_bank_fsm #(.LW(LW)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_claim_i (wr_go && wr_ptr_q == b[0]),
      .wr_done_i  (wr_end && wr_ptr_q == b[0]),
      .wr_len_i   (waddr_d),
      .rd_claim_i (rd_go && rd_ptr_q == b[0]),
      .rd_done_i  (rd_end && rd_ptr_q == b[0]),
      .st_o       (bst[b]),
      .len_o      (blen[b])
    );
  end
  // writer/reader next state, pointers, address counters and saturating error counters
  always_comb begin
    w_d      = wr_go ? W_ACTIVE : wr_drop ? W_DROP : wr_end ? W_IDLE : w_q;
    wr_ptr_d = wr_end ? ~wr_ptr_q : wr_ptr_q;
    waddr_d  = wbase + LW'(wbeat);
    r_d      = rd_go ? R_ACTIVE : rd_starve ? R_STARVE : (i_rd_eol && r_q != R_IDLE) ? R_IDLE : r_q;
    rd_ptr_d = rd_end ? ~rd_ptr_q : rd_ptr_q;
    raddr_d  = rbase + LW'(rbeat);
    ovf_d    = i_clr_err ? '0 : (wr_drop && ~&ovf_q) ? ovf_q + CNT_WIDTH'(1) : ovf_q;
    udf_d    = i_clr_err ? '0 : (rd_starve && ~&udf_q) ? udf_q + CNT_WIDTH'(1) : udf_q;
  end
  // control registers and read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= W_IDLE;
      r_q      <= R_IDLE;
      wr_ptr_q <= BANK1;
      rd_ptr_q <= BANK1;
      waddr_q  <= '0;
      raddr_q  <= '0;
      ovf_q    <= '0;
      udf_q    <= '0;
      vld_q    <= 1'b0;
      sel_q    <= BANK1;
    end else begin
      w_q      <= w_d;
      r_q      <= r_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= rbeat;
      sel_q    <= rbeat ? rd_ptr_q : sel_q;
    end
  end
  // port steering: unused lanes stay at zero so the two banks can be OR-combined
  always_comb begin
    o_we1   = wbeat && wr_ptr_q == BANK1;
    o_we2   = wbeat && wr_ptr_q == BANK2;
    o_cs1   = o_we1 || (rbeat && rd_ptr_q == BANK1);
    o_cs2   = o_we2 || (rbeat && rd_ptr_q == BANK2);
    o_addr1 = o_we1 ? wbase[ADDR_WIDTH-1:0] : o_cs1 ? rbase[ADDR_WIDTH-1:0] : '0;
    o_addr2 = o_we2 ? wbase[ADDR_WIDTH-1:0] : o_cs2 ? rbase[ADDR_WIDTH-1:0] : '0;
    o_din1  = o_we1 ? i_wr_data : '0;
    o_din2  = o_we2 ? i_wr_data : '0;
  end
  assign o_rd_valid = vld_q;
  assign o_sel      = sel_q;
  assign o_bank_st  = {bst[1], bst[0]};
  assign o_ovf_cnt  = ovf_q;
  assign o_udf_cnt  = udf_q;
endmodule

// File: tb/tb_linebuf_bank_ctrl.sv
// tb_linebuf_bank_ctrl: directed self-checking bench for the line buffer bank controller
module tb_linebuf_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_clr_err = 0, i_wr_sol = 0, i_wr_en = 0, i_wr_eol = 0;
  logic        i_rd_sol = 0, i_rd_en = 0, i_rd_eol = 0;
  logic [29:0] i_wr_data = '0;
  logic        o_cs1, o_cs2, o_we1, o_we2, o_rd_valid, o_sel;
  logic [5:0]  o_addr1, o_addr2;
  logic [29:0] o_din1, o_din2;
  logic [3:0]  o_bank_st;
  logic [7:0]  o_ovf_cnt, o_udf_cnt;
  int checks = 0;
  int errors = 0;
  linebuf_bank_ctrl dut (
    .clk(clk), .rst(rst), .i_clr_err(i_clr_err),
    .i_wr_sol(i_wr_sol), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .i_wr_eol(i_wr_eol),
    .i_rd_sol(i_rd_sol), .i_rd_en(i_rd_en), .i_rd_eol(i_rd_eol),
    .o_cs1(o_cs1), .o_cs2(o_cs2), .o_we1(o_we1), .o_we2(o_we2),
    .o_addr1(o_addr1), .o_addr2(o_addr2), .o_din1(o_din1), .o_din2(o_din2),
    .o_rd_valid(o_rd_valid), .o_sel(o_sel), .o_bank_st(o_bank_st),
    .o_ovf_cnt(o_ovf_cnt), .o_udf_cnt(o_udf_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_port(input string tag, input int b, input logic cs, input logic we, input int addr, input int din);
    #1;
    chk({tag, "_cs"}, b ? o_cs2 : o_cs1, cs);
    chk({tag, "_we"}, b ? o_we2 : o_we1, we);
    chk({tag, "_addr"}, b ? o_addr2 : o_addr1, addr);
    chk({tag, "_din"}, b ? o_din2 : o_din1, din);
    chk({tag, "_other_cs"}, b ? o_cs1 : o_cs2, 1'b0);
  endtask
  task automatic wr_line(input int n, input int b, input int base);
    if (n == 0) begin
      i_wr_sol = 1;
      tick;
    end
    for (int i = 0; i < n; i++) begin
      i_wr_sol = (i == 0);
      i_wr_en = 1;
      i_wr_data = 30'(base + i);
      if (i < 64) chk_port("wr", b, 1, 1, i, base + i);
      else chk_port("wr_over", b, 0, 0, 0, 0);
      tick;
    end
    i_wr_sol = 0;
    i_wr_en = 0;
    i_wr_eol = 1;
    tick;
    i_wr_eol = 0;
  endtask
  task automatic rd_line(input int n, input int b, input int exp_n);
    i_rd_sol = 1;
    tick;
    i_rd_sol = 0;
    for (int i = 0; i < n; i++) begin
      i_rd_en = 1;
      if (i < exp_n) chk_port("rd", b, 1, 0, i, 0);
      else chk_port("rd_over", b, 0, 0, 0, 0);
      tick;
      chk("rd_valid", o_rd_valid, i < exp_n);
      if (i < exp_n) chk("rd_sel", o_sel, b);
    end
    i_rd_en = 0;
    i_rd_eol = 1;
    tick;
    i_rd_eol = 0;
    chk("rd_valid_end", o_rd_valid, 0);
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    chk("rst_st", o_bank_st, 4'h0);
    chk("rst_ovf", o_ovf_cnt, 0);
    chk("rst_udf", o_udf_cnt, 0);
    chk("rst_cs1", o_cs1, 0);
    chk("rst_vld", o_rd_valid, 0);
    // 1: single line through bank1
    wr_line(4, 0, 100);
    chk("t1_full", o_bank_st, 4'h2);
    rd_line(4, 0, 4);
    chk("t1_empty", o_bank_st, 4'h0);
    // 2: both banks full, third line dropped
    wr_line(3, 1, 200);
    chk("t2_b2full", o_bank_st, 4'h8);
    wr_line(2, 0, 300);
    chk("t2_both", o_bank_st, 4'hA);
    i_wr_sol = 1;
    i_wr_en = 1;
    #1;
    chk("t2_drop_cs1", o_cs1, 0);
    chk("t2_drop_cs2", o_cs2, 0);
    tick;
    i_wr_sol = 0;
    #1;
    chk("t2_drop_cs1b", o_cs1, 0);
    chk("t2_drop_cs2b", o_cs2, 0);
    tick;
    i_wr_en = 0;
    i_wr_eol = 1;
    tick;
    i_wr_eol = 0;
    chk("t2_ovf", o_ovf_cnt, 1);
    chk("t2_st", o_bank_st, 4'hA);
    rd_line(3, 1, 3);
    chk("t2_drain2", o_bank_st, 4'h2);
    rd_line(2, 0, 2);
    chk("t2_drain1", o_bank_st, 4'h0);
    // 3: starved read
    i_rd_sol = 1;
    #1;
    chk("t3_cs1", o_cs1, 0);
    chk("t3_cs2", o_cs2, 0);
    tick;
    i_rd_sol = 0;
    chk("t3_udf", o_udf_cnt, 1);
    for (int i = 0; i < 2; i++) begin
      i_rd_en = 1;
      #1;
      chk("t3_nocs", o_cs1 | o_cs2, 0);
      tick;
      chk("t3_novld", o_rd_valid, 0);
    end
    i_rd_en = 0;
    i_rd_eol = 1;
    tick;
    i_rd_eol = 0;
    // 4: concurrent write bank2 while reading bank1
    rst = 1;
    tick;
    rst = 0;
    chk("t4_rst", o_bank_st, 4'h0);
    wr_line(4, 0, 400);
    i_wr_sol = 1;
    i_rd_sol = 1;
    tick;
    i_wr_sol = 0;
    i_rd_sol = 0;
    chk("t4_st", o_bank_st, 4'h7);
    for (int i = 0; i < 4; i++) begin
      i_wr_en = 1;
      i_rd_en = 1;
      i_wr_data = 30'(500 + i);
      #1;
      chk("t4_cs1", o_cs1, 1);
      chk("t4_cs2", o_cs2, 1);
      chk("t4_we1", o_we1, 0);
      chk("t4_we2", o_we2, 1);
      chk("t4_addr1", o_addr1, i);
      chk("t4_addr2", o_addr2, i);
      chk("t4_din2", o_din2, 500 + i);
      chk("t4_din1", o_din1, 0);
      tick;
      chk("t4_vld", o_rd_valid, 1);
      chk("t4_sel", o_sel, 0);
    end
    i_wr_en = 0;
    i_rd_en = 0;
    i_wr_eol = 1;
    i_rd_eol = 1;
    tick;
    i_wr_eol = 0;
    i_rd_eol = 0;
    chk("t4_end", o_bank_st, 4'h8);
    rd_line(4, 1, 4);
    chk("t4_drain", o_bank_st, 4'h0);
    // 5: overlong line saturates at capacity
    wr_line(70, 0, 1000);
    chk("t5_full", o_bank_st, 4'h2);
    rd_line(70, 0, 64);
    chk("t5_empty", o_bank_st, 4'h0);
    // zero-length line
    wr_line(0, 1, 0);
    chk("zl_full", o_bank_st, 4'h8);
    rd_line(2, 1, 0);
    chk("zl_empty", o_bank_st, 4'h0);
    // 6: same-cycle wr_eol/rd_sol, saturation, clear priority, mid-line reset
    rst = 1;
    tick;
    rst = 0;
    i_wr_sol = 1;
    i_wr_en = 1;
    i_wr_data = 30'd7;
    tick;
    i_wr_sol = 0;
    i_wr_en = 0;
    i_wr_eol = 1;
    i_rd_sol = 1;
    #1;
    chk("t6_nocs", o_cs1 | o_cs2, 0);
    tick;
    i_wr_eol = 0;
    i_rd_sol = 0;
    chk("t6_udf", o_udf_cnt, 1);
    chk("t6_st", o_bank_st, 4'h2);
    i_rd_eol = 1;
    tick;
    i_rd_eol = 0;
    wr_line(1, 1, 9);
    chk("t6_both", o_bank_st, 4'hA);
    for (int i = 0; i < 260; i++) begin
      i_wr_sol = 1;
      tick;
    end
    i_wr_sol = 0;
    chk("t6_sat", o_ovf_cnt, 8'hFF);
    i_wr_sol = 1;
    i_clr_err = 1;
    tick;
    i_wr_sol = 0;
    i_clr_err = 0;
    chk("t6_clr_ovf", o_ovf_cnt, 0);
    chk("t6_clr_udf", o_udf_cnt, 0);
    i_rd_sol = 1;
    tick;
    i_rd_sol = 0;
    chk("t6_reading", o_bank_st, 4'hB);
    i_rd_en = 1;
    #1;
    chk("t6_rd_cs", o_cs1, 1);
    rst = 1;
    tick;
    rst = 0;
    i_rd_en = 0;
    #1;
    chk("t6_rst_st", o_bank_st, 4'h0);
    chk("t6_rst_vld", o_rd_valid, 0);
    chk("t6_rst_cs", o_cs1 | o_cs2, 0);
    chk("t6_rst_ovf", o_ovf_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
